lsu_mem: RTL
============

Name: lsu_mem

Overview:
- Parametrised successor of the single-port data memory: byte-addressable, 2^ADDRW bytes, loads and stores in 1B/2B/4B size.
- Adds a valid/ready request/response handshake, configurable RAM wait states, and misaligned-access handling selected by parameter (fault or two-beat split).
- Sits between the core's MEM stage and the byte-enabled word RAM; exceptions are reported to the core's trap logic through resp_fault.

Parameters:
- ADDRW, 12, byte-address width; memory is 2^ADDRW bytes, organised as 2^(ADDRW-2) 32-bit words.
- WAIT_CYCLES, 0, extra idle cycles inserted before each RAM beat completes (0..15).
- ALLOW_MISALIGN, 0, 0 = misaligned access faults; 1 = misaligned access is split into two word beats.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  [1:0] size: 00 = B, 01 = H, 10 = W, 11 = illegal; [2]: 0 = sign-extend, 1 = zero-extend (loads only)
- req_addr  in  ADDRW  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_rdata  out  32  load result, extended; 0 for stores and faults
- resp_fault  out  1  1 = access faulted; no memory state was changed

Behaviour:
- Reset values: req_ready = 0 during rst, then 1 from the first cycle after release. resp_valid = 0, resp_rdata = 0, resp_fault = 0. FSM returns to IDLE. Asserting rst mid-access abandons the access; a split store may leave only its first beat written.
- FSM states: IDLE, BEAT0, BEAT1, RESP. req_ready = 1 only in IDLE, so one access is outstanding at a time.
- Request capture: at acceptance, register we, funct3, addr and wdata. Decode:
  - misaligned = (H and addr[0]) or (W and addr[1:0] != 0).
  - Fault condition = size 11, or (misaligned and ALLOW_MISALIGN = 0).
- Fault path: IDLE -> RESP with resp_fault = 1 and resp_rdata = 0. No RAM write enable is asserted. resp_valid rises in the cycle after acceptance (T+1).
- Aligned path: IDLE -> BEAT0.
  - A wait counter counts WAIT_CYCLES, then the RAM beat issues.
  - Byte enable = {0001, 0011, 1111}[size] << addr[1:0]. Write data = wdata << 8*addr[1:0].
  - The RAM read is synchronous (1 cycle).
  - BEAT0 -> RESP. resp_valid at T+1+WAIT_CYCLES+1.
- Split path (ALLOW_MISALIGN = 1, misaligned): BEAT0 then BEAT1, each with its own WAIT_CYCLES wait, then RESP.
  - With k = addr[1:0] and m = the size mask (0011 or 1111), the full enable is the 8-bit value m << k:
    - BEAT0 targets word w = addr[ADDRW-1:2] with be = low 4 bits of (m << k).
    - BEAT1 targets word (w+1) mod 2^(ADDRW-2), which wraps at the top of memory, with be = high 4 bits of (m << k).
  - Store data is the 64-bit value wdata << 8k, split low/high across the two beats.
  - For loads, the two read words are concatenated {hi, lo} >> 8k and then extended.
  - resp_valid at T+2*(WAIT_CYCLES+1)+1.
- Load extension: the B result uses bit 7 and the H result uses bit 15 when funct3[2] = 0; otherwise upper bits are zero. A W load returns the raw word.
- RESP state:
  - resp_valid, resp_rdata and resp_fault are held stable until resp_ready.
  - On handshake, go to IDLE. req_ready rises the following cycle; same-cycle turnaround is not supported.
- Simultaneous events: req_valid while busy is ignored, and the requester must hold it. Changes to req inputs while req_ready = 0 have no effect.

Decomposition:
- Shared package/macro header holds:
  - the size codes ML_BYTE/ML_HALF/ML_WORD;
  - the sign-select code;
  - the FSM state encodings;
  - a function returning the base byte mask for a size.
- Sub-module: the existing byte-enabled, synchronous-read word RAM `ram`, instantiated with ADDRW-2 address bits and DATAW 32.
- The FSM, wait counter, alignment/shift logic and extension live in lsu_mem.

Test Plan:
- Reset mid-access: assert rst during BEAT0 of a store to word 3 -> resp_valid = 0 immediately; word 3 unchanged; req_ready = 1 one cycle after release.
- Aligned word round trip: with WAIT_CYCLES = 0, SW 0xDEADBEEF to 0x010, then LW 0x010 -> rdata = 0xDEADBEEF, fault = 0, resp_valid at T+2.
- Sub-word loads: SB 0x80 to 0x021, then LB 0x021 -> 0xFFFFFF80; LBU 0x021 -> 0x00000080; LH 0x020 -> 0xFFFF80xx, where the low byte is unchanged.
- Misalign fault: with ALLOW_MISALIGN = 0, SW 0x12345678 to 0x006 -> resp_fault = 1, rdata = 0 at T+1; LW 0x004 shows the prior value. Size 11 also faults.
- Split with wrap: with ALLOW_MISALIGN = 1, ADDRW = 12, WAIT_CYCLES = 2, SW 0xAABBCCDD to 0xFFE -> bytes 0xFFE = DD, 0xFFF = CC, 0x000 = BB, 0x001 = AA; LW 0xFFE returns 0xAABBCCDD at T+7.
- Backpressure: hold resp_ready = 0 for 5 cycles after a load -> resp_valid and resp_rdata stay stable, req_ready stays 0, and a new req_valid is not accepted until after the handshake.

Source files
------------

// File: rtl/lsu_mem_pkg.sv
// Shared size/sign codes, FSM states and helper functions for the load/store unit.
// Pure declarations: no latency, no backpressure.
package lsu_mem_pkg;

  localparam logic [1:0] ML_BYTE = 2'b00;
  localparam logic [1:0] ML_HALF = 2'b01;
  localparam logic [1:0] ML_WORD = 2'b10;

  // funct3[2] value that selects sign extension on loads
  localparam logic ML_SEXT = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      ML_BYTE: return 4'b0001;
      ML_HALF: return 4'b0011;
      ML_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] funct3);
    logic sx;
    sx = (funct3[2] == ML_SEXT);
    case (funct3[1:0])
      ML_BYTE: return {{24{sx & raw[7]}}, raw[7:0]};
      ML_HALF: return {{16{sx & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ram.sv
// Byte-enabled word RAM with synchronous read; read data appears the cycle after en.
// No backpressure: every enabled cycle performs the access; rdata holds until the next en.
module ram #(
  parameter int ADDRW = 10,
  parameter int DATAW = 32
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [DATAW/8-1:0]   be,
  input  logic [ADDRW-1:0]     addr,
  input  logic [DATAW-1:0]     wdata,
  output logic [DATAW-1:0]     rdata
);

  logic [DATAW-1:0] mem [2**ADDRW];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DATAW/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit: one access in flight, response 1 cycle (fault) or WAIT_CYCLES+2 per aligned access, 2*(WAIT_CYCLES+1)+1 split.
// req_ready only in IDLE; the response is held stable until resp_ready.
module lsu_mem
  import lsu_mem_pkg::*;
#(
  parameter int ADDRW          = 12,
  parameter int WAIT_CYCLES    = 0,
  parameter int ALLOW_MISALIGN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDRW-1:0]  req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault
);

  localparam int WW = ADDRW - 2;

  lsu_state_t       state;
  logic [3:0]       wait_cnt;
  lsu_req_t         r_req;
  logic [ADDRW-1:0] r_addr;
  logic             r_split;
  logic [31:0]      lo_word;

  logic [1:0] in_size;
  logic       in_misalign;
  logic       in_fault;
  logic       accept;

  assign in_size     = req_funct3[1:0];
  assign in_misalign = (in_size == ML_HALF && req_addr[0]) ||
                       (in_size == ML_WORD && req_addr[1:0] != 2'b00);
  assign in_fault    = (in_size == 2'b11) || (in_misalign && ALLOW_MISALIGN == 0);
  assign accept      = req_valid && req_ready;

  // Alignment: an 8-byte window spanning the addressed word and its successor
  logic [1:0]    k;
  logic [7:0]    be_wide;
  logic [63:0]   wdata_wide;
  logic [WW-1:0] word0;
  logic [WW-1:0] word1;

  assign k          = r_addr[1:0];
  assign be_wide    = {4'b0000, size_mask(r_req.funct3[1:0])} << k;
  assign wdata_wide = {32'b0, r_req.wdata} << {k, 3'b000};
  assign word0      = r_addr[ADDRW-1:2];
  assign word1      = word0 + WW'(1);

  logic in_beat;
  logic beat_go;

  assign in_beat = (state == BEAT0) || (state == BEAT1);
  assign beat_go = in_beat && (wait_cnt == 4'(WAIT_CYCLES));

  logic          ram_en;
  logic [3:0]    ram_be;
  logic [WW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  assign ram_en    = beat_go;
  assign ram_be    = r_req.we ? ((state == BEAT1) ? be_wide[7:4] : be_wide[3:0]) : 4'b0000;
  assign ram_addr  = (state == BEAT1) ? word1 : word0;
  assign ram_wdata = (state == BEAT1) ? wdata_wide[63:32] : wdata_wide[31:0];

  ram #(
    .ADDRW (WW),
    .DATAW (32)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM output is untouched while in RESP, so the load result stays stable under backpressure
  logic [31:0] rd_raw;

  assign rd_raw     = 32'((r_split ? {ram_rdata, lo_word} : {32'b0, ram_rdata}) >> {k, 3'b000});
  assign resp_rdata = (resp_valid && !resp_fault && !r_req.we) ?
                      load_extend(rd_raw, r_req.funct3) : 32'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      r_req      <= '0;
      r_addr     <= '0;
      r_split    <= 1'b0;
      lo_word    <= 32'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            r_req     <= {req_we, req_funct3, req_wdata};
            r_addr    <= req_addr;
            r_split   <= in_misalign;
            wait_cnt  <= 4'd0;
            req_ready <= 1'b0;
            if (in_fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else begin
              state <= BEAT0;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        BEAT0: begin
          if (beat_go) begin
            wait_cnt <= 4'd0;
            if (r_split) begin
              state <= BEAT1;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        BEAT1: begin
          if (beat_go) begin
            lo_word    <= ram_rdata;
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
